// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared encodings and constants for the AES round control path
package aes_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ROUND = ST_ROUND,
        FINAL = ST_FINAL,
        DONE  = ST_DONE
    } state_t;

    localparam int NR_AES128     = 10;
    localparam int NR_AES192     = 12;
    localparam int NR_AES256     = 14;
    localparam int CNT_W_DEFAULT = 4;

endpackage

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES round control FSM driving the external round counter
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             ready,
    input  logic [CNT_W-1:0] round_count,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_value,
    output logic             cnt_inc,
    output logic             cnt_dec,
    output logic             data_load,
    output logic             round_en,
    output logic             final_round,
    output logic             key_step,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             error
);

    localparam logic [CNT_W-1:0] C_NR    = CNT_W'(NR);
    localparam logic [CNT_W-1:0] C_NR_M1 = CNT_W'(NR - 1);

    state_t r_state;
    state_t w_next_state;
    logic   r_error;
    logic   w_fault;

    // State register and sticky counter-consistency flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_fault) begin
                r_error <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; abort and counter faults park the counter at 0
    always_comb begin
        w_next_state   = r_state;
        w_fault        = 1'b0;
        ready          = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_inc        = 1'b0;
        data_load      = 1'b0;
        round_en       = 1'b0;
        final_round    = 1'b0;
        key_step       = 1'b0;
        out_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start && !abort) begin
                    data_load      = 1'b1;
                    key_step       = 1'b1;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(1);
                    w_next_state   = ROUND;
                end
            end
            ROUND: begin
                if (abort) begin
                    cnt_load     = 1'b1;
                    w_next_state = IDLE;
                end else if (round_count == '0 || round_count >= C_NR) begin
                    w_fault      = 1'b1;
                    cnt_load     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    round_en = 1'b1;
                    key_step = 1'b1;
                    cnt_inc  = 1'b1;
                    if (round_count == C_NR_M1) begin
                        w_next_state = FINAL;
                    end
                end
            end
            FINAL: begin
                if (abort) begin
                    cnt_load     = 1'b1;
                    w_next_state = IDLE;
                end else if (round_count != C_NR) begin
                    w_fault      = 1'b1;
                    cnt_load     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    round_en     = 1'b1;
                    final_round  = 1'b1;
                    key_step     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    cnt_load     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign cnt_dec = 1'b0;
    assign error   = r_error;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM directly upstream of the AES round counter.
- Accepts a start request from the core/co-processor interface and drives the counter's load/increment/decrement strobes.
- Reads the counter's registered count back, and emits per-cycle datapath enables: initial AddRoundKey, full round, final round without MixColumns, key-schedule step.
- Holds the finished block behind a valid/ready handshake until the consumer takes it.

Parameters:
- NR, 10, number of AES rounds (10/12/14 for AES-128/192/256); must satisfy NR <= 2**CNT_W - 1.
- CNT_W, 4, width of the round counter bus.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to encrypt the block currently presented to the datapath
- abort  input  1  synchronous cancel of an in-flight operation
- ready  output  1  high only in IDLE; start is accepted when start && ready
- round_count  input  CNT_W  current value from the round counter (registered, one-cycle update)
- cnt_load  output  1  counter load strobe
- cnt_load_value  output  CNT_W  counter load value
- cnt_inc  output  1  counter increment strobe
- cnt_dec  output  1  counter decrement strobe; constant 0 in this block
- data_load  output  1  datapath latches plaintext and applies round-0 AddRoundKey
- round_en  output  1  datapath executes one round this cycle
- final_round  output  1  qualifies round_en: skip MixColumns
- key_step  output  1  key schedule advances one round key
- out_valid  output  1  ciphertext valid, held until accepted
- out_ready  input  1  downstream consumer accepts ciphertext
- error  output  1  sticky counter-consistency fault

Behaviour:
- Reset is synchronous, active-high.
  - State goes to IDLE.
  - All outputs are 0 except ready=1.
  - cnt_load_value=0; error cleared.
  - Reset wins over every other input, including mid-operation; no ciphertext is produced.
- States: IDLE, ROUND, FINAL, DONE. All outputs are Moore-decoded from state and round_count, except the IDLE accept strobes, which are Mealy on start.
- IDLE:
  - ready=1.
  - On start=1: data_load=1, key_step=1, cnt_load=1, cnt_load_value=1; next ROUND.
  - Otherwise stay in IDLE with all strobes 0.
- ROUND:
  - round_en=1, key_step=1, cnt_inc=1, final_round=0.
  - If round_count == NR-1, next FINAL; else stay in ROUND.
- FINAL:
  - round_en=1, final_round=1, key_step=1, cnt_inc=0; next DONE.
  - round_count must equal NR here.
- DONE:
  - out_valid=1, held stable.
  - On out_ready=1: next IDLE and out_valid drops the following cycle.
  - start is ignored in DONE (ready=0); there is no back-to-back bypass.
- Latency:
  - Accept cycle is t0; rounds 1..NR-1 occupy t1..t(NR-1); the final round is tN.
  - out_valid is first high at t(NR+1).
  - With immediate out_ready, ready returns at t(NR+2).
- start while ready=0 is ignored and not queued.
- abort=1 in ROUND, FINAL or DONE:
  - Next state IDLE.
  - That cycle: cnt_load=1, cnt_load_value=0, round_en=0, key_step=0, out_valid=0.
  - abort in IDLE has no effect; abort has priority over start in the same cycle.
- Consistency check:
  - Condition: in ROUND, round_count == 0 or round_count >= NR; or in FINAL, round_count != NR.
  - Response: set error (sticky until reset), next IDLE, cnt_load=1 with value 0, no out_valid.
- Strobe exclusivity: cnt_load and cnt_inc are never high together; cnt_dec is always 0.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - state encoding localparams (IDLE/ROUND/FINAL/DONE, 2 bits);
  - NR_AES128=10, NR_AES192=12, NR_AES256=14;
  - default CNT_W=4.
- No sub-module is natural.
  - The round counter stays an external instance wired by the parent.
  - Next-state and output decode live in this module.

Test Plan:
- Nominal NR=10, out_ready tied 1:
  - start at t0 gives data_load and cnt_load (value 1) at t0;
  - round_en t1..t10; final_round only at t10;
  - out_valid at t11 for 1 cycle; ready high again at t12.
- Backpressure: out_ready=0 for 5 cycles after t11 -> out_valid held 5+1 cycles, no strobes toggle, start pulses during DONE ignored.
- Abort at t4 (round_count=4) -> t4 cnt_load=1 value 0, round_en=0; t5 ready=1, out_valid never asserted.
- Reset asserted at t6 mid-ROUND -> next cycle state IDLE, all strobes 0, error=0; a new start completes normally in 12 cycles.
- Counter fault: force round_count=12 during ROUND (NR=10) -> error=1 next cycle and sticky; cnt_load value 0; no out_valid; error clears only on reset.
- NR=14, CNT_W=4: exactly 13 ROUND cycles plus 1 FINAL; out_valid at t15.
